// File: rtl/banked_register_file_pkg.sv
// Shared types and the architectural-to-physical register mapping for the
// ARMv4 banked register file.
package armv4_rf_pkg;

    typedef enum logic [2:0] {
        USR = 3'd0,
        FIQ = 3'd1,
        IRQ = 3'd2,
        SVC = 3'd3,
        ABT = 3'd4,
        UND = 3'd5,
        SYS = 3'd6
    } mode_t;

    localparam int          PHYS_REGS = 30;
    localparam logic [3:0]  PC_IDX    = 4'd15;

    // Clear-sequencer states
    localparam logic [0:0]  ST_CLEAR  = 1'b0;
    localparam logic [0:0]  ST_RUN    = 1'b1;

    // Physical layout:
    //   0..14  USR/SYS r0-r14 (shared by every mode unless banked)
    //   15..21 FIQ r8-r14
    //   22..23 IRQ r13-r14, 24..25 SVC, 26..27 ABT, 28..29 UND
    // r15 is not stored here; callers handle it before using this index.
    function automatic logic [4:0] phys_index(mode_t m, logic [3:0] a);
        logic [4:0] idx;
        idx = {1'b0, a};
        case (m)
            FIQ: if (a >= 4'd8 && a <= 4'd14) idx = {1'b0, a} + 5'd7;
            IRQ: if (a >= 4'd13 && a <= 4'd14) idx = {1'b0, a} + 5'd9;
            SVC: if (a >= 4'd13 && a <= 4'd14) idx = {1'b0, a} + 5'd11;
            ABT: if (a >= 4'd13 && a <= 4'd14) idx = {1'b0, a} + 5'd13;
            UND: if (a >= 4'd13 && a <= 4'd14) idx = {1'b0, a} + 5'd15;
            default: idx = {1'b0, a};  // USR, SYS and reserved encoding 7
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/banked_register_file_clear_seq.sv
// Post-reset clear sequencer: walks every physical entry once, writing zero,
// then hands the write port over to normal operation.
module rf_clear_seq
    import armv4_rf_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    output logic       clr_we,
    output logic [4:0] clr_addr,
    output logic       busy,
    output logic [0:0] state_dbg
);

    logic [0:0] state;
    logic [4:0] cnt;

    // CLEAR/RUN state and entry counter; reset restarts the walk from entry 0
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_CLEAR;
            cnt   <= '0;
        end else if (state == ST_CLEAR) begin
            if (cnt == 5'(PHYS_REGS - 1)) begin
                state <= ST_RUN;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 5'd1;
            end
        end
    end

    assign clr_we    = (state == ST_CLEAR);
    assign clr_addr  = cnt;
    assign busy      = (state == ST_CLEAR);
    assign state_dbg = state;

endmodule

// File: rtl/banked_register_file.sv
// ARMv4 banked register file: 30 mode-banked entries plus a dedicated PC,
// RD_PORTS registered read ports, optional write-first forwarding.
// Port protocol: no handshake. Inputs are sampled at every posedge while busy
// is low; re and we are plain per-cycle enables, and everything presented
// while busy is high is dropped.
module banked_register_file
    import armv4_rf_pkg::*;
#(
    parameter int              BUS      = 32,
    parameter int              RD_PORTS = 3,
    parameter bit              FORWARD  = 1'b1,
    parameter logic [BUS-1:0]  PC_RESET = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  mode_t                    mode,
    input  logic                     re,
    input  logic [RD_PORTS*4-1:0]    ra,
    output logic [RD_PORTS*BUS-1:0]  rdata,
    input  logic                     we,
    input  logic [3:0]               wa,
    input  logic [BUS-1:0]           wdata,
    input  logic [BUS-1:0]           pc_in,
    output logic [BUS-1:0]           pc_out,
    output logic                     busy
);

    logic [BUS-1:0]          mem [PHYS_REGS];
    logic [BUS-1:0]          pc_q;
    logic [RD_PORTS*BUS-1:0] rdata_q;
    logic [RD_PORTS*BUS-1:0] rd_next;

    logic       clr_we;
    logic [4:0] clr_addr;
    logic [0:0] clr_state;
    logic       in_clear;

    logic           wr_gpr;
    logic [4:0]     wr_phys;
    logic [BUS-1:0] pc_next;
    logic           mem_we;
    logic [4:0]     mem_addr;
    logic [BUS-1:0] mem_wdata;

    rf_clear_seq u_clear_seq (
        .clk       (clk),
        .rst       (rst),
        .clr_we    (clr_we),
        .clr_addr  (clr_addr),
        .busy      (busy),
        .state_dbg (clr_state)
    );

    assign in_clear = (clr_state == ST_CLEAR);

    // A write to r15 redirects the PC instead of touching the array
    assign wr_gpr  = we && (wa != PC_IDX);
    assign wr_phys = phys_index(mode, wa);
    assign pc_next = (we && (wa == PC_IDX)) ? wdata : pc_in;

    // The clear sequence owns the array write port until it finishes
    assign mem_we    = in_clear ? clr_we   : (wr_gpr && !rst);
    assign mem_addr  = in_clear ? clr_addr : wr_phys;
    assign mem_wdata = in_clear ? '0       : wdata;

    // Array write; no reset here, zeroing comes only from the clear walk
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    // Next read data per port: r15 sees the PC being loaded, otherwise the
    // array, optionally overridden by a same-cycle write to the same entry
    always_comb begin
        rd_next = '0;
        for (int i = 0; i < RD_PORTS; i++) begin
            if (ra[4*i +: 4] == PC_IDX)
                rd_next[BUS*i +: BUS] = pc_next;
            else if (FORWARD && wr_gpr && (wr_phys == phys_index(mode, ra[4*i +: 4])))
                rd_next[BUS*i +: BUS] = wdata;
            else
                rd_next[BUS*i +: BUS] = mem[phys_index(mode, ra[4*i +: 4])];
        end
    end

    // Registered PC and read ports; both pinned to reset values while clearing
    always_ff @(posedge clk) begin
        if (rst || in_clear) begin
            pc_q    <= PC_RESET;
            rdata_q <= '0;
        end else begin
            pc_q <= pc_next;
            if (re) rdata_q <= rd_next;
        end
    end

    assign pc_out = pc_q;
    assign rdata  = rdata_q;

endmodule

// File: doc/banked_register_file.md
# banked_register_file

Parametrised successor to the ARMv4 core's register bank. Provides ARMv4 mode banking (FIQ r8–r14; IRQ/SVC/ABT/UND r13–r14), a configurable number of registered read ports, optional write-to-read forwarding, and a dedicated PC register. Sits between decode (register addresses, current mode) and execute/writeback. Contents are cleared by a post-reset initialisation sequence, so no memory-initialisation file is needed.

## Interface
- BUS, 32, data width of every register and port
- RD_PORTS, 3, number of read ports (1–4)
- FORWARD, 1, 1 = write-first forwarding to reads of the same physical entry; 0 = read-old
- PC_RESET, 0, value loaded into PC on reset
- clk  in  1  single clock, all state updates on posedge
- rst  in  1  synchronous, active-high reset
- mode  in  3  current processor mode (mode_t); applies to reads and writes in the same cycle
- re  in  1  read enable; rdata updates only when high
- ra  in  RD_PORTS*4  read addresses; port i in bits [4i+3:4i]
- rdata  out  RD_PORTS*BUS  registered read data; port i in bits [BUS*i+BUS-1:BUS*i]
- we  in  1  write enable
- wa  in  4  write address
- wdata  in  BUS  write data
- pc_in  in  BUS  next PC, loaded every cycle unless overridden
- pc_out  out  BUS  registered PC
- busy  out  1  high while the clear sequence runs

## Operation
- Physical storage: 30 entries (r0–r14 for USR/SYS, FIQ r8–r14, r13–r14 for IRQ/SVC/ABT/UND) plus a separate PC register for r15.
- Mode mapping: (mode, arch index) → physical index via phys_index(). Encodings 6 and 7 (SYS, reserved) map as USR.
- States: CLEAR, RUN.
- CLEAR: a 5-bit counter walks 0..29 and writes zero to one entry per cycle. we, re and pc_in are ignored, rdata holds 0, and pc_out holds PC_RESET. After entry 29 is written: state ← RUN, busy ← 0.
- RUN, write: if we and wa≠15, mem[phys(wa,mode)] ← wdata. If we and wa=15, PC ← wdata and pc_in is ignored for that cycle. Otherwise PC ← pc_in.
- RUN, read: when re=1, rdata_i ← mem[phys(ra_i,mode)]. A read of r15 returns the PC value being loaded at that edge (wdata if we and wa=15, else pc_in). When re=0, rdata holds.
- Forwarding (FORWARD=1): if we, re and phys(wa,mode)=phys(ra_i,mode), rdata_i ← wdata. With FORWARD=0, rdata_i gets the pre-write contents. r15 reads always follow the rule above.
- Multiple read ports with the same address return identical data.

## Timing
- Reset: rst high at an edge forces state=CLEAR, counter=0, busy=1, rdata=0, pc_out=PC_RESET. This applies in any state, including mid-CLEAR, which restarts the counter at 0.
- busy stays high for exactly 30 cycles after the first edge with rst low. The first RUN access is accepted at the edge after busy falls.
- Read latency: 1 cycle (address at edge n, data valid after edge n).
- Write visibility: a write at edge n is visible to non-forwarded reads at edge n+1.
- pc_out latency: 1 cycle from pc_in or from a wdata write to r15.
- Mode change takes effect in the same cycle for both reads and writes; there is no pipelining of mode.

## Structure
- Package armv4_rf_pkg holds:
  - mode_t enum: USR=0, FIQ=1, IRQ=2, SVC=3, ABT=4, UND=5, SYS=6
  - PHYS_REGS=30
  - PC_IDX=15
  - function phys_index(mode_t, logic [3:0])
- Sub-module rf_clear_seq holds the CLEAR/RUN FSM and counter, with outputs clr_we, clr_addr and busy. The top level multiplexes the clear write port over the normal write port.
- Storage is a plain array with no reset on the array itself. The array is zeroed only through the clear sequence.

## Test plan
- Reset: rst for 1 cycle → busy=1 for 30 cycles, then 0. pc_out=PC_RESET throughout. Reading r0–r14 in every mode returns 0.
- Banking: in USR, write r13=0x1000; in SVC, write r13=0x2000; in FIQ, write r12=0xF12. Then read r13 in USR/SVC/IRQ → 0x1000 / 0x2000 / 0, and r12 in USR/FIQ → 0 / 0xF12. SYS reads r13 → 0x1000.
- Forwarding: r3 holds 0x11, then a same-cycle write r3=0xDEADBEEF with read r3 on all ports → rdata=0xDEADBEEF (FORWARD=1) or 0x11 (FORWARD=0). The next read returns 0xDEADBEEF in both cases.
- PC: pc_in=0x8 → pc_out=0x8 next cycle. Then we, wa=15, wdata=0x100, pc_in=0x10 → pc_out=0x100, and a read of r15 in the same cycle → 0x100.
- Reset mid-clear: rst reasserted 10 cycles into CLEAR → busy remains high for a full 30 cycles after rst drops. A write r1=0x55 issued during busy is ignored (r1 reads 0 afterwards).
- Hold: with re=0 and changing ra, rdata holds its last value. Writing r14 in IRQ leaves r14 in UND at 0.
